// File: rtl/ife_pkg.sv
// Shared constants for the IFE host controller: frame geometry, FSM state codes, filter modes.
package ife_pkg;

  localparam int unsigned IMG_W             = 128;
  localparam int unsigned AW_DEF            = 2 * $clog2(IMG_W);
  localparam int unsigned DW_DEF            = 8;
  localparam int unsigned START_TIMEOUT_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [1:0] SEL_MEAN3  = 2'd0;
  localparam logic [1:0] SEL_MEAN5  = 2'd1;
  localparam logic [1:0] SEL_MAX    = 2'd2;
  localparam logic [1:0] SEL_THRESH = 2'd3;

endpackage

// File: rtl/ife_drain_buf.sv
// Drains the result memory in raster order through a 1-deep output register,
// issuing 1-cycle sync reads only when the landing slot is guaranteed free.
module ife_drain_buf
  import ife_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] res_rdata,
  input  logic          out_ready,
  output logic [AW-1:0] rd_addr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          last_accept_c
);

  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          pend_q, pend_d;
  logic          pend_last_q, pend_last_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          issue_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // A read in flight always lands in a slot that was empty or emptied when it was issued.
  always_comb begin
    issue_c     = en && !rd_ptr_q[AW] && !pend_q && (!out_valid_q || out_ready);
    rd_ptr_d    = rd_ptr_q;
    pend_d      = issue_c;
    pend_last_d = issue_c && (rd_ptr_q == LAST_IDX);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (issue_c) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = res_rdata;
      out_last_d  = pend_last_q;
    end
    if (!en) begin
      rd_ptr_d    = '0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  assign rd_addr       = rd_ptr_q[AW] ? {AW{1'b1}} : rd_ptr_q[AW-1:0];
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign last_accept_c = out_valid_q && out_ready && out_last_q;

endmodule

// File: rtl/ife_host_ctrl.sv
// Host side of the IFE filter engine: loads a frame into source memory, hands it to the
// engine with a ready/busy handshake, passes engine traffic through, then drains the result.
module ife_host_ctrl
  import ife_pkg::*;
#(
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    cfg_sel,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ready,
  input  logic          busy,
  output logic [1:0]    sel,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_wr,
  input  logic          wen,
  output logic [AW-1:0] src_addr,
  output logic          src_we,
  output logic [DW-1:0] src_wdata,
  input  logic [DW-1:0] src_rdata,
  output logic [AW-1:0] res_addr,
  output logic          res_we,
  output logic [DW-1:0] res_wdata,
  input  logic [DW-1:0] res_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done,
  output logic          err_timeout
);

  localparam int unsigned TW        = $clog2(START_TIMEOUT + 1);
  localparam logic [AW:0] LAST_PIX  = {1'b0, {AW{1'b1}}};
  localparam logic [TW-1:0] TMO_END = TW'(START_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          last_accept_c;
  logic [AW-1:0] drain_addr_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      err_q      <= 1'b0;
      load_cnt_q <= '0;
      timer_q    <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      load_cnt_q <= load_cnt_d;
      timer_q    <= timer_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  // ready drops on the same edge that leaves START so the engine never sees it twice.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    err_d      = err_q;
    load_cnt_d = load_cnt_q;
    timer_d    = timer_q;
    ready_d    = ready_q;
    done_d     = last_accept_c;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          sel_d      = cfg_sel;
          err_d      = 1'b0;
          load_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          load_cnt_d = load_cnt_q + (AW+1)'(1);
          if (load_cnt_q == LAST_PIX) begin
            state_d = ST_START;
            ready_d = 1'b1;
            timer_d = '0;
          end
        end
      end
      ST_START: begin
        if (busy) begin
          state_d = ST_RUN;
          ready_d = 1'b0;
        end else if (timer_q == TMO_END) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (!busy) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_accept_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side steering; everything idles at zero outside its owning state.
  always_comb begin
    src_addr  = '0;
    src_we    = 1'b0;
    src_wdata = '0;
    idata     = '0;
    res_addr  = '0;
    res_we    = 1'b0;
    res_wdata = '0;
    case (state_q)
      ST_LOAD: begin
        src_addr  = load_cnt_q[AW-1:0];
        src_we    = in_valid;
        src_wdata = in_valid ? in_data : '0;
      end
      ST_RUN: begin
        src_addr  = iaddr;
        idata     = src_rdata;
        res_we    = wen;
        res_addr  = addr;
        res_wdata = data_wr;
      end
      ST_DRAIN: res_addr = drain_addr_c;
      default: ;
    endcase
  end

  ife_drain_buf #(.AW(AW), .DW(DW)) u_drain (
    .clk           (clk),
    .reset         (reset),
    .en            (state_q == ST_DRAIN),
    .res_rdata     (res_rdata),
    .out_ready     (out_ready),
    .rd_addr       (drain_addr_c),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .last_accept_c (last_accept_c)
  );

  assign in_ready    = (state_q == ST_LOAD);
  assign ready       = ready_q;
  assign sel         = sel_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ife_host_ctrl.sv
// Self-checking bench for ife_host_ctrl: external memories, a stand-in IFE engine and a
// frame-level reference; a reduced frame size keeps the run short.
module tb_ife_host_ctrl;
  import ife_pkg::*;

  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 16;
  localparam int          N   = 1 << AW;

  logic          clk, reset, start, in_valid, in_ready, ready, busy, wen;
  logic [1:0]    cfg_sel, sel;
  logic [DW-1:0] in_data, idata, data_wr, src_wdata, src_rdata, res_wdata, res_rdata, out_data;
  logic [AW-1:0] iaddr, addr, src_addr, res_addr;
  logic          src_we, res_we, out_valid, out_last, out_ready, done, err_timeout;

  ife_host_ctrl #(.AW(AW), .DW(DW), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_sel(cfg_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ready(ready), .busy(busy), .sel(sel),
    .iaddr(iaddr), .idata(idata), .addr(addr), .data_wr(data_wr), .wen(wen),
    .src_addr(src_addr), .src_we(src_we), .src_wdata(src_wdata), .src_rdata(src_rdata),
    .res_addr(res_addr), .res_we(res_we), .res_wdata(res_wdata), .res_rdata(res_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .err_timeout(err_timeout)
  );

  logic [DW-1:0] src_mem [N];
  logic [DW-1:0] res_mem [N];
  logic [DW-1:0] src_ref [N];
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: asynchronous read. Result memory: one-cycle synchronous read.
  assign src_rdata = src_mem[src_addr];
  always @(posedge clk) begin
    if (src_we) src_mem[src_addr] <= src_wdata;
    if (res_we) res_mem[res_addr] <= res_wdata;
    res_rdata <= res_mem[res_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in per-pixel filter so each mode yields a distinguishable result.
  function automatic logic [7:0] ref_filt(input logic [7:0] x, input logic [1:0] m);
    case (m)
      SEL_MEAN3: return x >> 1;
      SEL_MEAN5: return x + 8'd37;
      SEL_MAX:   return ~x;
      default:   return (x >= 8'd128) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic load_frame(input logic [1:0] mode, input bit gaps, input bit ramp);
    int i;
    int guard;
    bit v;
    logic [7:0] px;
    start = 1'b1; cfg_sel = mode;
    tick();
    start = 1'b0; cfg_sel = ~mode;
    check("in_ready_load", 32'(in_ready), 32'd1);
    check("err_cleared", 32'(err_timeout), 32'd0);
    check("sel_latched", 32'(sel), 32'(mode));
    i = 0; guard = 0;
    while (i < N && guard < 8 * N) begin
      v  = gaps ? 1'($urandom % 2) : 1'b1;
      px = ramp ? 8'(i % 256) : 8'($urandom);
      in_valid = v; in_data = px;
      #1;
      if (v) begin
        check("src_we", 32'(src_we), 32'd1);
        check("src_addr", 32'(src_addr), 32'(i));
        check("src_wdata", 32'(src_wdata), 32'(px));
        src_ref[i] = px;
        i++;
      end else begin
        check("src_we_gap", 32'(src_we), 32'd0);
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("load_count", 32'(i), 32'(N));
    check("ready_after_load", 32'(ready), 32'd1);
    check("in_ready_after_load", 32'(in_ready), 32'd0);
    for (int j = 0; j < N; j++) check("src_mem", 32'(src_mem[j]), 32'(src_ref[j]));
  endtask

  task automatic ife_run(input int wait_cyc, input logic [1:0] exp_sel, input bit poke_start);
    logic [7:0] d;
    for (int c = 0; c < wait_cyc; c++) begin
      check("ready_hold", 32'(ready), 32'd1);
      tick();
    end
    busy = 1'b1;
    tick();
    check("ready_drop", 32'(ready), 32'd0);
    for (int i = 0; i < N; i++) begin
      start   = poke_start && (i == 100);
      cfg_sel = ~exp_sel;
      iaddr   = AW'(i);
      #1;
      d       = idata;
      check("idata", 32'(d), 32'(src_ref[i]));
      addr    = AW'(i);
      data_wr = ref_filt(d, sel);
      wen     = 1'b1;
      #1;
      check("res_we", 32'(res_we), 32'd1);
      check("res_addr", 32'(res_addr), 32'(i));
      tick();
    end
    start = 1'b0; wen = 1'b0; busy = 1'b0;
    check("ready_run", 32'(ready), 32'd0);
    check("sel_kept", 32'(sel), 32'(exp_sel));
    tick();
    wen = 1'b1; addr = AW'(5); data_wr = 8'hAA;
    #1;
    check("wen_ignored", 32'(res_we), 32'd0);
    check("drain_addr0", 32'(res_addr), 32'd0);
    wen = 1'b0;
  endtask

  task automatic drain(input logic [1:0] exp_sel, input bit bp, input int stop_at);
    int k, cyc, dones, extra;
    bit hold;
    logic [7:0] held;
    k = 0; cyc = 0; dones = 0; extra = 0; hold = 1'b0; held = '0;
    while (cyc < 8 * N && (k < N || extra < 3)) begin
      if (done) dones++;
      if (k >= N) extra++;
      if (k == stop_at) begin
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_res_addr", 32'(res_addr), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0; out_ready = 1'b0;
        tick();
        return;
      end
      out_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held));
      end
      hold = 1'b0;
      if (out_valid && k >= N) begin
        check("extra_pixel", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        check("drain_data", 32'(out_data), 32'(ref_filt(src_ref[k], exp_sel)));
        check("drain_last", 32'(out_last), 32'(k == N - 1));
        k++;
      end else if (out_valid) begin
        hold = 1'b1;
        held = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", 32'(k), 32'(N));
    check("done_pulses", 32'(dones), 32'd1);
    check("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic timeout_case();
    int cnt;
    cnt = 0;
    while (ready && cnt < 40) begin
      cnt++;
      tick();
    end
    check("timeout_cycles", 32'(cnt), 32'(TMO));
    check("err_set", 32'(err_timeout), 32'd1);
    check("ready_cleared", 32'(ready), 32'd0);
    check("timeout_idle", 32'(in_ready), 32'd0);
    repeat (3) tick();
    check("err_sticky", 32'(err_timeout), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_sel = '0; in_valid = 1'b0; in_data = '0;
    busy = 1'b0; iaddr = '0; addr = '0; data_wr = '0; wen = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err_timeout), 32'd0);
    check("reset_src_we", 32'(src_we), 32'd0);
    check("reset_res_we", 32'(res_we), 32'd0);
    reset = 1'b0;
    tick();

    load_frame(SEL_MAX, 1'b0, 1'b1);
    ife_run(3, SEL_MAX, 1'b0);
    drain(SEL_MAX, 1'b0, -1);

    load_frame(SEL_THRESH, 1'b1, 1'b0);
    ife_run(0, SEL_THRESH, 1'b1);
    drain(SEL_THRESH, 1'b1, -1);

    load_frame(SEL_MEAN5, 1'b0, 1'b0);
    timeout_case();

    load_frame(SEL_MEAN3, 1'b0, 1'b1);
    ife_run(7, SEL_MEAN3, 1'b0);
    drain(SEL_MEAN3, 1'b0, 500);

    load_frame(SEL_MAX, 1'b1, 1'b1);
    ife_run(14, SEL_MAX, 1'b0);
    drain(SEL_MAX, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
